// File: rtl/spinner_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spinner_multi
// Brief    : Animates a top/bottom half-ring glyph across NUM_DIGITS
//            seven-segment digits (bounce / rotate / hold modes) and drives a
//            time-multiplexed active-low anode scan.
// Revision : 1.0 - initial release
// ============================================================================
module spinner_multi #(
  parameter int NUM_DIGITS = 8,
  parameter int TICK_DIV   = 1000000,
  parameter int SCAN_DIV   = 100000,
  parameter int SPEED_W    = 3
) (
  input  logic                          CLK100MHZ,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          dir,
  input  logic [1:0]                    mode,
  input  logic [SPEED_W-1:0]            speed,
  output logic [7:0]                    seg,
  output logic [NUM_DIGITS-1:0]         AN,
  output logic [$clog2(NUM_DIGITS)-1:0] pos,
  output logic                          phase,
  output logic                          step_pulse
);

  localparam int POS_W = $clog2(NUM_DIGITS);

  // Prescaler must hold the longest step period (slowest speed setting).
  localparam longint unsigned C_MAX_PERIOD = longint'(TICK_DIV) << ((1 << SPEED_W) - 1);
  localparam int PRE_W = $clog2(C_MAX_PERIOD + 1);
  localparam int SC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PRE_W-1:0]      C_TICK      = PRE_W'(TICK_DIV);
  localparam logic [PRE_W-1:0]      C_PRE_ONE   = PRE_W'(1);
  localparam logic [POS_W-1:0]      C_POS_LAST  = POS_W'(NUM_DIGITS - 1);
  localparam logic [POS_W-1:0]      C_POS_ZERO  = '0;
  localparam logic [POS_W-1:0]      C_POS_ONE   = POS_W'(1);
  localparam logic [SC_W-1:0]       C_SCAN_LAST = SC_W'(SCAN_DIV - 1);
  localparam logic [SC_W-1:0]       C_SCAN_ONE  = SC_W'(1);
  localparam logic [NUM_DIGITS-1:0] C_AN_ONE    = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  // Glyphs are active-high with CA in the MSB; the pins are active-low.
  localparam logic [7:0] C_GLYPH_BOT = 8'b0011_1010;
  localparam logic [7:0] C_GLYPH_TOP = 8'b1100_0110;
  localparam logic [7:0] C_SEG_BLANK = 8'hFF;

  localparam logic [1:0] C_MODE_BOUNCE = 2'd0;
  localparam logic [1:0] C_MODE_ROTATE = 2'd1;

  logic [PRE_W-1:0]      presc_q,      presc_d;
  logic [POS_W-1:0]      pos_q,        pos_d;
  logic                  phase_q,      phase_d;
  logic                  step_pulse_q, step_pulse_d;
  logic [SC_W-1:0]       scan_cnt_q,   scan_cnt_d;
  logic [POS_W-1:0]      scan_idx_q,   scan_idx_d;
  logic [NUM_DIGITS-1:0] an_q,         an_d;
  logic [7:0]            seg_q,        seg_d;

  logic [PRE_W-1:0]      w_period;
  logic                  w_step;
  logic                  w_scan_adv;

  // Step timing: >= compare lets a speed decrease take effect immediately.
  always_comb begin
    w_period     = C_TICK << speed;
    w_step       = en && (presc_q >= (w_period - C_PRE_ONE));
    presc_d      = presc_q;
    step_pulse_d = w_step;
    if (en) begin
      presc_d = w_step ? '0 : (presc_q + C_PRE_ONE);
    end
  end

  // Animation position/phase update, evaluated only on a step.
  always_comb begin
    pos_d   = pos_q;
    phase_d = phase_q;
    if (w_step) begin
      case (mode)
        C_MODE_BOUNCE: begin
          // Phase 0 travels in the dir direction, phase 1 travels back.
          if (dir ^ phase_q) begin
            if (pos_q == C_POS_LAST) phase_d = ~phase_q;
            else                     pos_d   = pos_q + C_POS_ONE;
          end else begin
            if (pos_q == C_POS_ZERO) phase_d = ~phase_q;
            else                     pos_d   = pos_q - C_POS_ONE;
          end
        end
        C_MODE_ROTATE: begin
          if (dir) begin
            if (pos_q == C_POS_LAST) begin
              pos_d   = C_POS_ZERO;
              phase_d = ~phase_q;
            end else begin
              pos_d   = pos_q + C_POS_ONE;
            end
          end else begin
            if (pos_q == C_POS_ZERO) begin
              pos_d   = C_POS_LAST;
              phase_d = ~phase_q;
            end else begin
              pos_d   = pos_q - C_POS_ONE;
            end
          end
        end
        default: begin
          pos_d   = pos_q;
          phase_d = phase_q;
        end
      endcase
    end
  end

  // Free-running scan divider and digit index, independent of the animation.
  always_comb begin
    w_scan_adv = (scan_cnt_q == C_SCAN_LAST);
    scan_cnt_d = w_scan_adv ? '0 : (scan_cnt_q + C_SCAN_ONE);
    scan_idx_d = scan_idx_q;
    if (w_scan_adv) begin
      scan_idx_d = (scan_idx_q == C_POS_LAST) ? C_POS_ZERO : (scan_idx_q + C_POS_ONE);
    end
  end

  // Pin drive: one anode low per slot; glyph only on the digit holding it.
  always_comb begin
    an_d  = ~(C_AN_ONE << scan_idx_q);
    seg_d = C_SEG_BLANK;
    if (scan_idx_q == pos_q) begin
      seg_d = ~(phase_q ? C_GLYPH_TOP : C_GLYPH_BOT);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      presc_q      <= '0;
      pos_q        <= '0;
      phase_q      <= 1'b0;
      step_pulse_q <= 1'b0;
      scan_cnt_q   <= '0;
      scan_idx_q   <= '0;
      an_q         <= ~C_AN_ONE;
      seg_q        <= ~C_GLYPH_BOT;
    end else begin
      presc_q      <= presc_d;
      pos_q        <= pos_d;
      phase_q      <= phase_d;
      step_pulse_q <= step_pulse_d;
      scan_cnt_q   <= scan_cnt_d;
      scan_idx_q   <= scan_idx_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign seg        = seg_q;
  assign AN         = an_q;
  assign pos        = pos_q;
  assign phase      = phase_q;
  assign step_pulse = step_pulse_q;

endmodule
`default_nettype wire
